// File: rtl/keypad_scan_encoder.sv
// Keypad scanner: steps the 12:1 mux select, debounces press/release,
// and reports one registered key code per accepted press.
module keypad_scan_encoder #(
  parameter int DWELL    = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scan_en,
  input  logic       key_in,
  output logic [3:0] sel_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_busy
);

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int HW = $clog2(DEBOUNCE + 1);

  localparam logic [DW-1:0] DW_LAST = DW'(DWELL - 1);
  localparam logic [HW-1:0] DB_N    = HW'(DEBOUNCE);
  localparam logic [HW-1:0] DB_ONE  = HW'(1);

  typedef enum logic [1:0] {
    SCAN = 2'd0,
    DEB  = 2'd1,
    HELD = 2'd2
  } state_t;

  state_t        state;
  logic [DW-1:0] dwell;
  logic [HW-1:0] hits;
  logic [HW-1:0] rel;

  logic       sample;
  logic [3:0] next_sel;

  assign sample   = (dwell == DW_LAST);
  assign next_sel = (sel_out == 4'd11) ? 4'd0 : sel_out + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SCAN;
      dwell     <= '0;
      hits      <= '0;
      rel       <= '0;
      sel_out   <= 4'd0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_busy  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      unique case (state)
        SCAN: begin
          if (scan_en) begin
            if (sample) begin
              dwell <= '0;
              if (key_in) begin
                if (DB_N == DB_ONE) begin
                  key_code  <= sel_out;
                  key_valid <= 1'b1;
                  key_busy  <= 1'b1;
                  rel       <= '0;
                  hits      <= '0;
                  state     <= HELD;
                end else begin
                  hits  <= DB_ONE;
                  state <= DEB;
                end
              end else begin
                sel_out <= next_sel;
              end
            end else begin
              dwell <= dwell + DW'(1);
            end
          end
        end
        DEB: begin
          // Losing scan_en abandons the candidate but keeps the select
          if (!scan_en) begin
            dwell <= '0;
            hits  <= '0;
            state <= SCAN;
          end else if (sample) begin
            dwell <= '0;
            if (key_in) begin
              if (hits + DB_ONE == DB_N) begin
                key_code  <= sel_out;
                key_valid <= 1'b1;
                key_busy  <= 1'b1;
                rel       <= '0;
                hits      <= '0;
                state     <= HELD;
              end else begin
                hits <= hits + DB_ONE;
              end
            end else begin
              hits    <= '0;
              sel_out <= next_sel;
              state   <= SCAN;
            end
          end else begin
            dwell <= dwell + DW'(1);
          end
        end
        HELD: begin
          if (sample) begin
            dwell <= '0;
            if (key_in) begin
              rel <= '0;
            end else if (rel + DB_ONE == DB_N) begin
              rel      <= '0;
              key_busy <= 1'b0;
              sel_out  <= next_sel;
              state    <= SCAN;
            end else begin
              rel <= rel + DB_ONE;
            end
          end else begin
            dwell <= dwell + DW'(1);
          end
        end
        default: begin
          state <= SCAN;
        end
      endcase
    end
  end

endmodule
